// File: rtl/round_robin_distributor.sv
// Buffered fan-out of one write stream to N downstream FIFO write ports.
// Words leave the buffer head one per cycle in round-robin channel order.
module round_robin_distributor #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int STRICT     = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_write,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    output logic                       o_wr_full,
    input  logic                       i_block_dist,
    input  logic [N-1:0]               i_wr_full,
    output logic [N-1:0]               o_write,
    output logic [DATA_WIDTH-1:0]      o_wr_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(N)-1:0]       o_ptr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(N);
    localparam logic [PW:0]   LP_N    = (PW+1)'(N);
    localparam logic [PW-1:0] LP_LAST = PW'(N - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [PW-1:0]         r_ptr;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_disp;
    logic                  w_gnt_vld;
    logic [PW-1:0]         w_gnt;
    logic [PW:0]           w_c;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_accept = i_write && !w_full;

    // Reverse scan so the last hit is the first non-full channel from r_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_ptr;
        w_c       = '0;
        if (STRICT != 0) begin
            w_gnt_vld = !i_wr_full[r_ptr];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                w_c = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_c >= LP_N) begin
                    w_c = w_c - LP_N;
                end
                if (!i_wr_full[w_c[PW-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = w_c[PW-1:0];
                end
            end
        end
    end

    assign w_disp    = !w_empty && !i_block_dist && w_gnt_vld;
    assign o_write   = w_disp ? (N'(1) << w_gnt) : '0;
    assign o_wr_data = r_mem[r_rptr[AW-1:0]];
    assign o_wr_full = w_full;
    assign o_count   = r_wptr - r_rptr;
    assign o_ptr     = r_ptr;

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ptr  <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_disp) begin
                r_rptr <= r_rptr + 1'b1;
                r_ptr  <= (w_gnt == LP_LAST) ? '0 : w_gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_distributor.sv
// Bench for round_robin_distributor: skip (STRICT=0) and strict (STRICT=1)
// instances share stimulus; a list-based model checks both every cycle.
module tb_round_robin_distributor;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] din;
    logic       blk;
    logic [3:0] full;

    logic       owf0, owf1;
    logic [3:0] ow0, ow1;
    logic [7:0] od0, od1;
    logic [2:0] cnt0, cnt1;
    logic [1:0] ptr0, ptr1;

    int n_chk;
    int n_pass;

    round_robin_distributor #(.N(4), .DATA_WIDTH(8), .DEPTH(4), .STRICT(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_write(wr), .i_wr_data(din),
        .o_wr_full(owf0), .i_block_dist(blk), .i_wr_full(full),
        .o_write(ow0), .o_wr_data(od0), .o_count(cnt0), .o_ptr(ptr0)
    );

    round_robin_distributor #(.N(4), .DATA_WIDTH(8), .DEPTH(4), .STRICT(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_write(wr), .i_wr_data(din),
        .o_wr_full(owf1), .i_block_dist(blk), .i_wr_full(full),
        .o_write(ow1), .o_wr_data(od1), .o_count(cnt1), .o_ptr(ptr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Model: per instance an ordered list of buffered words and a next-channel index.
    logic [7:0] mbuf [2][4];
    int         mcnt [2];
    int         mptr [2];

    function automatic int exp_grant(input int s, input logic [3:0] f, input logic b);
        if (mcnt[s] == 0 || b) return -1;
        for (int k = 0; k < 4; k++) begin
            int c = (mptr[s] + k) % 4;
            if (!f[c]) return c;
            if (s == 1) return -1;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                mcnt[s] = 0;
                mptr[s] = 0;
            end
            chk("rst_write0", ow0, 0);
            chk("rst_write1", ow1, 0);
            chk("rst_count0", cnt0, 0);
            chk("rst_ptr1", ptr1, 0);
            chk("rst_full0", owf0, 0);
        end else begin
            for (int s = 0; s < 2; s++) begin
                int g;
                int ew;
                bit acc;
                g  = exp_grant(s, full, blk);
                ew = (g < 0) ? 0 : (1 << g);
                chk(s ? "m_write1" : "m_write0", s ? ow1 : ow0, ew);
                if (g >= 0) chk(s ? "m_data1" : "m_data0", s ? od1 : od0, mbuf[s][0]);
                chk(s ? "m_count1" : "m_count0", s ? cnt1 : cnt0, mcnt[s]);
                chk(s ? "m_wfull1" : "m_wfull0", s ? owf1 : owf0, int'(mcnt[s] == 4));
                chk(s ? "m_ptr1" : "m_ptr0", s ? ptr1 : ptr0, mptr[s]);
                acc = wr && (mcnt[s] != 4);
                if (g >= 0) begin
                    for (int i = 0; i < 3; i++) mbuf[s][i] = mbuf[s][i+1];
                    mcnt[s]--;
                    mptr[s] = (g + 1) % 4;
                end
                if (acc) begin
                    mbuf[s][mcnt[s]] = din;
                    mcnt[s]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        wr     = 1'b0;
        din    = 8'h00;
        blk    = 1'b0;
        full   = 4'b0000;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("init_count", cnt0, 0);
        chk("init_ptr", ptr0, 0);

        // Back-to-back stream: one-cycle latency, rotating one-hot strobes.
        for (int k = 0; k <= 8; k++) begin
            wr  = (k < 8);
            din = 8'h10 + 8'(k);
            #1;
            chk("seq_write", ow0, (k == 0) ? 0 : (1 << ((k - 1) % 4)));
            if (k > 0) chk("seq_data", od0, 8'h10 + k - 1);
            cyc();
        end
        wr = 1'b0;
        cyc();

        // Channel 1 full with pointer at 1: skip vs strict wait.
        wr = 1'b1; din = 8'h20;
        cyc();
        din = 8'h21; #1;
        chk("pre_write0", ow0, 4'b0001);
        cyc();
        wr = 1'b0; full = 4'b0010; #1;
        chk("skip_write0", ow0, 4'b0100);
        chk("skip_data0", od0, 8'h21);
        chk("strict_stall", ow1, 0);
        cyc(); #1;
        chk("skip_ptr0", ptr0, 3);
        chk("strict_ptr1", ptr1, 1);
        cyc(); cyc();
        full = 4'b0000; #1;
        chk("strict_write1", ow1, 4'b0010);
        chk("strict_data1", od1, 8'h21);
        cyc(); #1;
        chk("strict_ptr_after", ptr1, 2);

        // Buffer overflow: fifth word dropped while all channels full.
        full = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; din = 8'hA0 + 8'(i); #1;
            if (i == 3) chk("ovf_full_before", owf0, 0);
            if (i == 4) chk("ovf_full", owf0, 1);
            if (i == 4) chk("ovf_count", cnt0, 4);
            cyc();
        end
        wr = 1'b0; #1;
        chk("ovf_count_hold", cnt0, 4);
        full = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_write0", ow0, 1 << ((3 + i) % 4));
            chk("drain_data0", od0, 8'hA0 + i);
            chk("drain_write1", ow1, 1 << ((2 + i) % 4));
            chk("drain_data1", od1, 8'hA0 + i);
            cyc();
        end
        chk("drain_empty", cnt1, 0);

        // Block holds dispatch and pointer, then two back-to-back dispatches.
        blk = 1'b1; wr = 1'b1; din = 8'hB0;
        cyc();
        din = 8'hB1;
        cyc();
        wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("blk_write0", ow0, 0);
            chk("blk_ptr0", ptr0, 3);
            cyc();
        end
        blk = 1'b0; #1;
        chk("rel_write0a", ow0, 4'b1000);
        chk("rel_data0a", od0, 8'hB0);
        chk("rel_write1a", ow1, 4'b0100);
        cyc(); #1;
        chk("rel_write0b", ow0, 4'b0001);
        chk("rel_data0b", od0, 8'hB1);
        chk("rel_write1b", ow1, 4'b1000);
        cyc();

        // Reset with three words buffered and pointer at 2.
        wr = 1'b1; din = 8'hC0;
        cyc();
        wr = 1'b0;
        cyc();
        blk = 1'b1; wr = 1'b1;
        for (int i = 1; i < 4; i++) begin
            din = 8'hC0 + 8'(i);
            cyc();
        end
        wr = 1'b0; #1;
        chk("pre_rst_count", cnt0, 3);
        chk("pre_rst_ptr", ptr0, 2);
        blk = 1'b0; rst_n = 1'b0; #1;
        chk("rst_now_count", cnt0, 0);
        chk("rst_now_ptr", ptr0, 0);
        chk("rst_now_write", ow0, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_write0", ow0, 0);
            chk("post_rst_write1", ow1, 0);
            cyc();
        end

        // Mixed traffic patterns checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            wr   = (i % 3 != 0);
            din  = 8'(8'h40 + i);
            full = 4'((i * 5) % 16);
            blk  = (i % 7 == 3);
            cyc();
        end
        wr = 1'b0; full = 4'b0000; blk = 1'b0;
        repeat (10) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
